// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings for the writeback select stage.
// Holds the writeback source codes, the load funct3 codes and the
// datapath-width legality check used at elaboration time.
package wb_pkg;

  // Writeback source select codes
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // Load type codes (funct3 of the load instruction)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Only RV32 and RV64 datapaths are supported
  function automatic bit xlen_is_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  // Two to four writeback sources are supported
  function automatic bit num_src_is_legal(input int num_src);
    return (num_src >= 2) && (num_src <= 4);
  endfunction

endpackage

// File: rtl/wb_select_stage_load_extract.sv
// load_extract: combinational sub-word extraction of a raw data-memory word.
// The byte lane comes from the low address bits, aligned down to the access
// size; the selected byte/half/word is then sign- or zero-extended to XLEN.
// On a 32-bit datapath the top lane bit is ignored and LD/LWU/111 act as LW.
module load_extract
  import wb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] read_data,
  input  logic [2:0]      load_funct3,
  input  logic [2:0]      addr_lsb,
  output logic [XLEN-1:0] load_data
);

  logic [2:0]      lane_s;
  logic [XLEN-1:0] shifted_s;

  // Pick the byte lane, aligned down to the access size
  always_comb begin
    lane_s = 3'd0;
    case (load_funct3)
      F3_LB, F3_LBU: lane_s = addr_lsb;
      F3_LH, F3_LHU: lane_s = {addr_lsb[2:1], 1'b0};
      F3_LW, F3_LWU: lane_s = {addr_lsb[2], 2'b00};
      default:       lane_s = 3'd0;
    endcase
    if (XLEN == 32) begin
      lane_s[2] = 1'b0;
    end else begin
      lane_s[2] = lane_s[2];
    end
  end

  assign shifted_s = read_data >> {lane_s, 3'b000};

  // Extend the selected field to the full datapath width
  always_comb begin
    load_data = shifted_s;
    case (load_funct3)
      F3_LB:   load_data = XLEN'(signed'(shifted_s[7:0]));
      F3_LH:   load_data = XLEN'(signed'(shifted_s[15:0]));
      F3_LW:   load_data = XLEN'(signed'(shifted_s[31:0]));
      F3_LD:   load_data = shifted_s;
      F3_LBU:  load_data = XLEN'(shifted_s[7:0]);
      F3_LHU:  load_data = XLEN'(shifted_s[15:0]);
      F3_LWU:  load_data = XLEN'(shifted_s[31:0]);
      default: load_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// wb_select_stage: MEM/WB pipeline register with the writeback source mux.
// Selects ALU / load / PC+4 / immediate, registers it with flush > stall >
// capture priority and drives the register-file write port. x0 is never
// written. Optional macro WB_BYPASS_EN adds a registered forwarding port.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NUM_SRC = 4,
  parameter int REG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        wb_sel,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   read_data,
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic [XLEN-1:0]   imm,
  input  logic [2:0]        load_funct3,
  input  logic [2:0]        addr_lsb,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              reg_write_in,
`ifdef WB_BYPASS_EN
  output logic              byp_valid,
  output logic [REG_AW-1:0] byp_rd,
  output logic [XLEN-1:0]   byp_data,
`endif
  output logic              wb_valid,
  output logic              reg_write,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   write_data
);

  generate
    if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
      $error("wb_select_stage: XLEN must be 32 or 64");
    end
    if (!num_src_is_legal(NUM_SRC)) begin : g_bad_num_src
      $error("wb_select_stage: NUM_SRC must be 2..4");
    end
  endgenerate

  logic [XLEN-1:0]   load_data_s;
  logic [XLEN-1:0]   sel_data_s;
  logic              wb_valid_d, wb_valid_q;
  logic              reg_write_d, reg_write_q;
  logic [REG_AW-1:0] rd_d, rd_q;
  logic [XLEN-1:0]   write_data_d, write_data_q;

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .read_data   (read_data),
    .load_funct3 (load_funct3),
    .addr_lsb    (addr_lsb),
    .load_data   (load_data_s)
  );

  // Writeback source mux; codes beyond the configured sources fall back to ALU
  always_comb begin
    sel_data_s = alu_result;
    if ({30'd0, wb_sel} >= 32'(NUM_SRC)) begin
      sel_data_s = alu_result;
    end else begin
      case (wb_sel)
        WB_ALU:  sel_data_s = alu_result;
        WB_MEM:  sel_data_s = load_data_s;
        WB_PC4:  sel_data_s = pc_plus4;
        WB_IMM:  sel_data_s = imm;
        default: sel_data_s = alu_result;
      endcase
    end
  end

  // Next state of the stage register: flush empties, stall holds, else capture
  always_comb begin
    wb_valid_d   = wb_valid_q;
    reg_write_d  = reg_write_q;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    if (flush) begin
      wb_valid_d  = 1'b0;
      reg_write_d = 1'b0;
    end else if (stall) begin
      wb_valid_d  = wb_valid_q;
      reg_write_d = reg_write_q;
    end else begin
      wb_valid_d   = in_valid;
      reg_write_d  = in_valid & reg_write_in & (rd_in != {REG_AW{1'b0}});
      rd_d         = rd_in;
      write_data_d = sel_data_s;
    end
  end

  // Stage register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= {REG_AW{1'b0}};
      write_data_q <= {XLEN{1'b0}};
    end else begin
      wb_valid_q   <= wb_valid_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
    end
  end

  assign wb_valid   = wb_valid_q;
  assign reg_write  = reg_write_q;
  assign rd         = rd_q;
  assign write_data = write_data_q;

`ifdef WB_BYPASS_EN
  assign byp_valid = reg_write_q & wb_valid_q;
  assign byp_rd    = rd_q;
  assign byp_data  = write_data_q;
`endif

endmodule

// File: tb/tb_wb_select_stage.sv
// tb_wb_select_stage: table-driven vectors, hand-written corner sequences and
// randomized stimulus against a behavioural model. Drives a 64-bit, 4-source
// instance and a 32-bit, 2-source instance with shared stimulus.
module tb_wb_select_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [1:0]  wb_sel = 2'd0;
  logic [63:0] alu_result = 64'd0, read_data = 64'd0, pc_plus4 = 64'd0, imm = 64'd0;
  logic [2:0]  load_funct3 = 3'd0, addr_lsb = 3'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        reg_write_in = 1'b0;

  logic        v64, rw64, v32, rw32;
  logic [4:0]  rd64, rd32;
  logic [63:0] wd64;
  logic [31:0] wd32;
`ifdef WB_BYPASS_EN
  logic        bv64, bv32;
  logic [4:0]  brd64, brd32;
  logic [63:0] bd64;
  logic [31:0] bd32;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_select_stage #(.XLEN(64), .NUM_SRC(4), .REG_AW(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_sel(wb_sel), .alu_result(alu_result), .read_data(read_data),
    .pc_plus4(pc_plus4), .imm(imm), .load_funct3(load_funct3), .addr_lsb(addr_lsb),
    .rd_in(rd_in), .reg_write_in(reg_write_in),
`ifdef WB_BYPASS_EN
    .byp_valid(bv64), .byp_rd(brd64), .byp_data(bd64),
`endif
    .wb_valid(v64), .reg_write(rw64), .rd(rd64), .write_data(wd64)
  );

  wb_select_stage #(.XLEN(32), .NUM_SRC(2), .REG_AW(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_sel(wb_sel), .alu_result(alu_result[31:0]), .read_data(read_data[31:0]),
    .pc_plus4(pc_plus4[31:0]), .imm(imm[31:0]), .load_funct3(load_funct3),
    .addr_lsb(addr_lsb), .rd_in(rd_in), .reg_write_in(reg_write_in),
`ifdef WB_BYPASS_EN
    .byp_valid(bv32), .byp_rd(brd32), .byp_data(bd32),
`endif
    .wb_valid(v32), .reg_write(rw32), .rd(rd32), .write_data(wd32)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          valid;
    bit          rw;
    logic [4:0]  rd;
    logic [63:0] wd;
    bit          wd_known;
  } exp_t;

  exp_t m64, m32;

  function automatic exp_t reset_state();
    exp_t s;
    s.valid = 1'b0; s.rw = 1'b0; s.rd = 5'd0; s.wd = 64'd0; s.wd_known = 1'b1;
    return s;
  endfunction

  // Load result from access size, lane alignment and signedness
  function automatic logic [63:0] ref_load(input logic [63:0] w, input logic [2:0] f3,
                                           input logic [2:0] lsb, input int xl);
    int nbytes, off;
    bit sgn;
    logic [63:0] v, mask;
    nbytes = 1 << f3[1:0];
    sgn = (f3[2] == 1'b0) && (f3 != 3'b011);
    if (xl == 32 && nbytes > 4) nbytes = 4;
    if (xl == 32 && f3 == 3'b111) nbytes = 4;
    if (xl == 32) w = w & 64'h00000000FFFFFFFF;
    off = ((int'(lsb) % (xl / 8)) / nbytes) * nbytes;
    v = w >> (off * 8);
    mask = (nbytes == 8) ? 64'hFFFFFFFFFFFFFFFF : ((64'd1 << (nbytes * 8)) - 64'd1);
    v = v & mask;
    if (sgn && nbytes < 8 && v[nbytes * 8 - 1]) v = v | ~mask;
    if (xl == 32) v = v & 64'h00000000FFFFFFFF;
    return v;
  endfunction

  function automatic logic [63:0] ref_sel(input int xl, input int nsrc);
    int src;
    logic [63:0] r;
    src = (int'(wb_sel) >= nsrc) ? 0 : int'(wb_sel);
    if (src == 1) r = ref_load(read_data, load_funct3, addr_lsb, xl);
    else if (src == 2) r = pc_plus4;
    else if (src == 3) r = imm;
    else r = alu_result;
    if (xl == 32) r = r & 64'h00000000FFFFFFFF;
    return r;
  endfunction

  function automatic exp_t next_state(input exp_t s, input int xl, input int nsrc);
    exp_t n;
    n = s;
    if (flush) begin
      n.valid = 1'b0; n.rw = 1'b0;
    end else if (!stall) begin
      n.valid = in_valid;
      n.rw = in_valid && reg_write_in && (rd_in != 5'd0);
      n.rd = rd_in;
      n.wd = ref_sel(xl, nsrc);
      n.wd_known = in_valid;
    end
    return n;
  endfunction

  // ---------------- checking ----------------
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".valid64"}, {63'd0, v64}, {63'd0, m64.valid});
    cmp({tag, ".rw64"}, {63'd0, rw64}, {63'd0, m64.rw});
    cmp({tag, ".rd64"}, {59'd0, rd64}, {59'd0, m64.rd});
    if (m64.wd_known) cmp({tag, ".wd64"}, wd64, m64.wd);
    cmp({tag, ".valid32"}, {63'd0, v32}, {63'd0, m32.valid});
    cmp({tag, ".rw32"}, {63'd0, rw32}, {63'd0, m32.rw});
    cmp({tag, ".rd32"}, {59'd0, rd32}, {59'd0, m32.rd});
    if (m32.wd_known) cmp({tag, ".wd32"}, {32'd0, wd32}, m32.wd);
`ifdef WB_BYPASS_EN
    cmp({tag, ".byp_valid64"}, {63'd0, bv64}, {63'd0, (m64.rw && m64.valid)});
    cmp({tag, ".byp_rd64"}, {59'd0, brd64}, {59'd0, m64.rd});
    if (m64.wd_known) cmp({tag, ".byp_data64"}, bd64, m64.wd);
    cmp({tag, ".byp_valid32"}, {63'd0, bv32}, {63'd0, (m32.rw && m32.valid)});
    if (m32.wd_known) cmp({tag, ".byp_data32"}, {32'd0, bd32}, m32.wd);
`endif
  endtask

  // One clock: model advances on the same edge as the DUT, then compare
  task automatic step(input string tag);
    exp_t n64, n32;
    n64 = next_state(m64, 64, 4);
    n32 = next_state(m32, 32, 2);
    @(posedge clk);
    #1;
    m64 = n64;
    m32 = n32;
    check_all(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  sel;
    logic [63:0] alu;
    logic [63:0] rdat;
    logic [63:0] pc4;
    logic [63:0] im;
    logic [2:0]  f3;
    logic [2:0]  lsb;
    logic [4:0]  rdi;
    logic        rwi;
    logic [63:0] exp_wd;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[14];
  localparam logic [63:0] LD_WORD = 64'h8877665544332211;

  initial begin
    vecs[0]  = '{2'd0, 64'h1F, 64'h0, 64'h0, 64'h0, 3'b011, 3'd0, 5'd3, 1'b1, 64'h1F, 1'b1};
    vecs[1]  = '{2'd1, 64'h1F, 64'h0, 64'h0, 64'h0, 3'b011, 3'd0, 5'd3, 1'b1, 64'h0, 1'b1};
    vecs[2]  = '{2'd2, 64'h1F, 64'h0, 64'h104, 64'h0, 3'b011, 3'd0, 5'd4, 1'b1, 64'h104, 1'b1};
    vecs[3]  = '{2'd1, 64'h0, LD_WORD, 64'h0, 64'h0, 3'b000, 3'd7, 5'd5, 1'b1, 64'hFFFFFFFFFFFFFF88, 1'b1};
    vecs[4]  = '{2'd1, 64'h0, LD_WORD, 64'h0, 64'h0, 3'b100, 3'd7, 5'd6, 1'b1, 64'h88, 1'b1};
    vecs[5]  = '{2'd1, 64'h0, LD_WORD, 64'h0, 64'h0, 3'b001, 3'd2, 5'd7, 1'b1, 64'h4433, 1'b1};
    vecs[6]  = '{2'd1, 64'h0, LD_WORD, 64'h0, 64'h0, 3'b010, 3'd4, 5'd8, 1'b1, 64'hFFFFFFFF88776655, 1'b1};
    vecs[7]  = '{2'd1, 64'h0, LD_WORD, 64'h0, 64'h0, 3'b110, 3'd4, 5'd9, 1'b1, 64'h88776655, 1'b1};
    vecs[8]  = '{2'd3, 64'h0, 64'h0, 64'h0, 64'hABCDE000, 3'b000, 3'd0, 5'd10, 1'b1, 64'hABCDE000, 1'b1};
    vecs[9]  = '{2'd0, 64'h55, 64'h0, 64'h0, 64'h0, 3'b000, 3'd0, 5'd0, 1'b1, 64'h55, 1'b0};
    vecs[10] = '{2'd1, 64'h0, LD_WORD, 64'h0, 64'h0, 3'b001, 3'd3, 5'd11, 1'b1, 64'h4433, 1'b1};
    vecs[11] = '{2'd1, 64'h0, LD_WORD, 64'h0, 64'h0, 3'b101, 3'd7, 5'd12, 1'b1, 64'h8877, 1'b1};
    vecs[12] = '{2'd1, 64'h0, LD_WORD, 64'h0, 64'h0, 3'b011, 3'd5, 5'd13, 1'b1, LD_WORD, 1'b1};
    vecs[13] = '{2'd0, 64'h77, 64'h0, 64'h0, 64'h0, 3'b000, 3'd0, 5'd14, 1'b0, 64'h77, 1'b0};
  end

  // ---------------- main sequence ----------------
  logic [4:0]  snap_rd;
  logic [63:0] snap_wd;

  initial begin
    m64 = reset_state();
    m32 = reset_state();

    // Reset applies before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #6;

    // Table vectors, one capture per cycle
    for (int i = 0; i < 14; i++) begin
      wb_sel = vecs[i].sel; alu_result = vecs[i].alu; read_data = vecs[i].rdat;
      pc_plus4 = vecs[i].pc4; imm = vecs[i].im; load_funct3 = vecs[i].f3;
      addr_lsb = vecs[i].lsb; rd_in = vecs[i].rdi; reg_write_in = vecs[i].rwi;
      in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
      step($sformatf("vec%0d", i));
      cmp($sformatf("vec%0d.table_wd", i), wd64, vecs[i].exp_wd);
      cmp($sformatf("vec%0d.table_rw", i), {63'd0, rw64}, {63'd0, vecs[i].exp_rw});
    end

    // 32-bit datapath: LD at lsb 4 behaves as LW of the low word
    wb_sel = 2'd1; read_data = 64'h0000000080000000; load_funct3 = 3'b011;
    addr_lsb = 3'd4; rd_in = 5'd1; reg_write_in = 1'b1; in_valid = 1'b1;
    step("ld32");
    cmp("ld32.table_wd32", {32'd0, wd32}, 64'h80000000);
    cmp("ld32.table_wd64", wd64, 64'h80000000);

    // 2-source build: select codes 2/3 fall back to ALU
    wb_sel = 2'd3; alu_result = 64'hDEAD0001; imm = 64'h12345000;
    step("unused_sel");
    cmp("unused_sel.table_wd32", {32'd0, wd32}, 64'hDEAD0001);
    cmp("unused_sel.table_wd64", wd64, 64'h12345000);

    // Stall for three cycles while inputs change: outputs frozen
    snap_rd = rd64; snap_wd = wd64;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_sel = 2'($urandom_range(0, 3)); alu_result = {$urandom, $urandom};
      read_data = {$urandom, $urandom}; rd_in = 5'(i + 20); in_valid = 1'b1;
      step($sformatf("stall%0d", i));
      cmp($sformatf("stall%0d.frozen_wd", i), wd64, snap_wd);
      cmp($sformatf("stall%0d.frozen_rd", i), {59'd0, rd64}, {59'd0, snap_rd});
      cmp($sformatf("stall%0d.frozen_rw", i), {63'd0, rw64}, 64'd1);
    end

    // Flush together with stall: stage emptied, data held
    flush = 1'b1;
    step("flush_stall");
    cmp("flush_stall.valid", {63'd0, v64}, 64'd0);
    cmp("flush_stall.rw", {63'd0, rw64}, 64'd0);
    cmp("flush_stall.wd_hold", wd64, snap_wd);
    flush = 1'b0; stall = 1'b0;

    // Capture a write, then reset mid-cycle with no clock edge
    wb_sel = 2'd0; alu_result = 64'h0123456789ABCDEF; rd_in = 5'd17;
    reg_write_in = 1'b1; in_valid = 1'b1;
    step("pre_reset");
    rst_n = 1'b0;
    #1;
    m64 = reset_state();
    m32 = reset_state();
    check_all("midreset");
    #3 rst_n = 1'b1;

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      stall        = ($urandom_range(0, 5) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      wb_sel       = 2'($urandom_range(0, 3));
      alu_result   = {$urandom, $urandom};
      read_data    = {$urandom, $urandom};
      pc_plus4     = {$urandom, $urandom};
      imm          = {$urandom, $urandom};
      load_funct3  = 3'($urandom_range(0, 7));
      addr_lsb     = 3'($urandom_range(0, 7));
      rd_in        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      reg_write_in = ($urandom_range(0, 3) != 0);
      step($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
